dmi_jtag_frontend: RTL
======================

DMI_JTAG_FRONTEND -- requirements
Module: dmi_jtag_frontend

Interface
REQ-001 SHALL have parameter AddrWidth, default 7, DMI address width (1..32).
REQ-002 SHALL have parameter DataWidth, default 32, DMI data width (8..64).
REQ-003 SHALL have parameter TimeoutCycles, default 1024, response-timeout limit in tck cycles (>=2).
REQ-004 SHALL expose ports, with DW = AddrWidth+DataWidth+2:
- tck_i  in  1  sole clock; all state on posedge.
- trst_ni  in  1  reset, asynchronous, active-low.
- test_logic_reset_i, capture_dr_i, shift_dr_i, update_dr_i  in  1 each  TAP state strobes.
- dmi_access_i, dtmcs_select_i  in  1 each  IR decode.
- dmi_reset_i, dmi_hard_reset_i  in  1 each  dtmcs dmireset / dmihardreset.
- dmi_tdi_i  in  1  serial in; dmi_tdo_o  out  1  serial out (= dr_q[0]).
- dmi_error_o  out  2  sticky error to dtmcs.
- dmi_req_o  out  AddrWidth+DataWidth+2  {addr, data, op}.
- dmi_req_valid_o  out  1; dmi_req_ready_i  in  1.
- dmi_resp_i  in  DataWidth+2  {data, resp}.
- dmi_resp_valid_i  in  1; dmi_resp_ready_o  out  1.

Function
REQ-005 SHALL use ops 0=NOP, 1=READ, 2=WRITE, 3=reserved (treated as NOP); error codes 0=OK, 2=FAILED, 3=BUSY.
REQ-006 SHALL implement FSM IDLE, REQ, WAIT_RESP; op_q holds the latched op.
REQ-007 IDLE: on update_dr_i & dmi_access_i & error_q==0 & DR op in {1,2}, SHALL latch addr/data/op from DR and go to REQ next cycle; NOP/reserved leaves state unchanged.
REQ-008 REQ: dmi_req_valid_o SHALL be 1 and held with stable payload until dmi_req_ready_i; on handshake go to WAIT_RESP.
REQ-009 WAIT_RESP: on dmi_resp_valid_i SHALL go to IDLE; for READ, data_q <= resp data; if resp!=0 and error_q!=3, error_q <= 2 (FAILED).
REQ-010 dmi_resp_ready_o SHALL be 1 in WAIT_RESP or while discard_q=1, else 0.
REQ-011 update_dr_i with dmi_access_i while state!=IDLE SHALL set error_q=3 and drop the update.
REQ-012 capture_dr_i with dmi_access_i while state!=IDLE SHALL set error_q=3; captured DR SHALL read {addr_q, data_q, 3}.
REQ-013 capture_dr_i with dmi_access_i otherwise SHALL load DR {addr_q, data_q, error_q}.
REQ-014 shift_dr_i with dmi_access_i SHALL shift DR right, dmi_tdi_i into MSB, one bit per cycle.
REQ-015 update with error_q!=0 SHALL be ignored; error_q SHALL stay sticky.
REQ-016 dmi_reset_i & dtmcs_select_i SHALL clear error_q to 0; same-cycle busy set SHALL lose to the clear.
REQ-017 dmi_hard_reset_i SHALL clear error_q; in WAIT_RESP go to IDLE and set discard_q; in REQ finish the handshake, then go to IDLE with discard_q set.
REQ-018 discard_q=1 SHALL consume and drop the next response without updating data_q/error_q, then clear.
REQ-019 test_logic_reset_i SHALL clear DR only; FSM, error_q, and in-flight transfers SHALL be unaffected.

Reset
REQ-020 trst_ni low SHALL asynchronously force state IDLE, DR/addr_q/data_q/op_q 0, error_q 0, discard_q 0, timeout count 0; dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_tdo_o=0.
REQ-021 Reset assertion mid-transfer SHALL abort it with no further handshake activity.

Configuration
REQ-022 Macro DMI_JTAG_FRONTEND_TIMEOUT_EN defined: counter increments each WAIT_RESP cycle; reaching TimeoutCycles without a response SHALL force IDLE, error_q=2, discard_q=1.
REQ-023 Macro undefined: no counter, WAIT_RESP SHALL wait indefinitely.

Verification (AddrWidth=7, DataWidth=32)
REQ-024 Shift op=2 addr=0x10 data=0xDEADBEEF, update, ready=1 -> one valid cycle with dmi_req_o={0x10,0xDEADBEEF,2}; resp 0 -> IDLE, error 0.
REQ-025 Read addr=0x11, resp {0x12345678,0} after 3 cycles, next capture -> DR={0x11,0x12345678,0}.
REQ-026 Capture while WAIT_RESP -> DR op field 3, dmi_error_o=3; later updates ignored until dmi_reset_i & dtmcs_select_i -> 0.
REQ-027 Response resp=2 on write -> dmi_error_o=2; following update with op=1 -> no request issued.
REQ-028 Hard reset in WAIT_RESP, then late response -> IDLE, resp consumed, data_q unchanged, error 0.
REQ-029 With macro, TimeoutCycles=8, no response -> IDLE after exactly 8 WAIT_RESP cycles, dmi_error_o=2; without macro -> stays WAIT_RESP.

Source files
------------

// File: rtl/dmi_jtag_frontend.sv
`default_nettype none
// ============================================================================
// Module   : dmi_jtag_frontend
// Purpose  : JTAG DTM front end for the RISC-V Debug Module Interface (DMI).
//            It captures, shifts and updates the DMI data register, turns
//            accepted updates into DMI requests, collects the responses and
//            keeps a sticky error code that dtmcs reports.
// Optional : define DMI_JTAG_FRONTEND_TIMEOUT_EN to abort a transfer whose
//            response has not arrived within TimeoutCycles tck cycles.
// Ports    : tck_i / trst_ni           - clock, async active-low reset
//            test_logic_reset_i, capture_dr_i, shift_dr_i, update_dr_i
//                                      - TAP state strobes
//            dmi_access_i, dtmcs_select_i - IR decode
//            dmi_reset_i, dmi_hard_reset_i - dtmcs dmireset / dmihardreset
//            dmi_tdi_i / dmi_tdo_o     - serial data in / out
//            dmi_error_o               - sticky error (0 OK, 2 FAILED, 3 BUSY)
//            dmi_req_o/_valid_o/_ready_i    - {addr, data, op} request
//            dmi_resp_i/_valid_i/_ready_o   - {data, resp} response
// Revision : 1.0 - initial release
// ============================================================================
module dmi_jtag_frontend #(
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                           tck_i,
  input  logic                           trst_ni,
  input  logic                           test_logic_reset_i,
  input  logic                           capture_dr_i,
  input  logic                           shift_dr_i,
  input  logic                           update_dr_i,
  input  logic                           dmi_access_i,
  input  logic                           dtmcs_select_i,
  input  logic                           dmi_reset_i,
  input  logic                           dmi_hard_reset_i,
  input  logic                           dmi_tdi_i,
  output logic                           dmi_tdo_o,
  output logic [1:0]                     dmi_error_o,
  output logic [AddrWidth+DataWidth+1:0] dmi_req_o,
  output logic                           dmi_req_valid_o,
  input  logic                           dmi_req_ready_i,
  input  logic [DataWidth+1:0]           dmi_resp_i,
  input  logic                           dmi_resp_valid_i,
  output logic                           dmi_resp_ready_o
);

  localparam int unsigned DrWidth = AddrWidth + DataWidth + 2;

  localparam logic [1:0] OpRead   = 2'd1;
  localparam logic [1:0] OpWrite  = 2'd2;
  localparam logic [1:0] ErrOk    = 2'd0;
  localparam logic [1:0] ErrFail  = 2'd2;
  localparam logic [1:0] ErrBusy  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DrWidth-1:0]     dr_q, dr_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [1:0]             op_q, op_d;
  logic [1:0]             error_q, error_d;
  logic                   discard_q, discard_d;
  // Hard reset seen while the request was still waiting for ready.
  logic                   abort_q, abort_d;

  logic [1:0]             dr_op;
  logic [DataWidth-1:0]   dr_data;
  logic [AddrWidth-1:0]   dr_addr;
  logic [1:0]             resp_code;
  logic [DataWidth-1:0]   resp_data;
  logic                   busy;

  assign dr_op     = dr_q[1:0];
  assign dr_data   = dr_q[DataWidth+1:2];
  assign dr_addr   = dr_q[DrWidth-1:DataWidth+2];
  assign resp_code = dmi_resp_i[1:0];
  assign resp_data = dmi_resp_i[DataWidth+1:2];

  // Any DR access that reaches capture or update while a transfer is in
  // flight is a busy violation.
  assign busy = dmi_access_i & (capture_dr_i | update_dr_i) & (state_q != IDLE);

`ifdef DMI_JTAG_FRONTEND_TIMEOUT_EN
  localparam int unsigned CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  logic [CntWidth-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    dr_d      = dr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    error_d   = error_q;
    discard_d = discard_q;
    abort_d   = abort_q;
`ifdef DMI_JTAG_FRONTEND_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    // A pending discard swallows the next response regardless of state.
    if (discard_q && dmi_resp_valid_i) begin
      discard_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (update_dr_i && dmi_access_i && (error_q == ErrOk) &&
            ((dr_op == OpRead) || (dr_op == OpWrite))) begin
          addr_d  = dr_addr;
          data_d  = dr_data;
          op_d    = dr_op;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmi_req_ready_i) begin
          if (abort_q || dmi_hard_reset_i) begin
            // The request went out, so its response must be dropped.
            state_d   = IDLE;
            discard_d = 1'b1;
            abort_d   = 1'b0;
          end else begin
            state_d = WAIT_RESP;
`ifdef DMI_JTAG_FRONTEND_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end else if (dmi_hard_reset_i) begin
          abort_d = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (dmi_resp_valid_i && !discard_q) begin
          state_d = IDLE;
          if (op_q == OpRead) begin
            data_d = resp_data;
          end
          if ((resp_code != ErrOk) && (error_q != ErrBusy)) begin
            error_d = ErrFail;
          end
        end else if (dmi_hard_reset_i) begin
          state_d   = IDLE;
          discard_d = 1'b1;
        end
`ifdef DMI_JTAG_FRONTEND_TIMEOUT_EN
        else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
          state_d   = IDLE;
          error_d   = ErrFail;
          discard_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (busy) begin
      error_d = ErrBusy;
    end
    // Clears win over any error raised in the same cycle.
    if ((dmi_reset_i && dtmcs_select_i) || dmi_hard_reset_i) begin
      error_d = ErrOk;
    end

    if (test_logic_reset_i) begin
      dr_d = '0;
    end else if (capture_dr_i && dmi_access_i) begin
      dr_d = {addr_q, data_q, (state_q != IDLE) ? ErrBusy : error_q};
    end else if (shift_dr_i && dmi_access_i) begin
      dr_d = {dmi_tdi_i, dr_q[DrWidth-1:1]};
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q   <= IDLE;
      dr_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= '0;
      error_q   <= '0;
      discard_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dr_q      <= dr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      error_q   <= error_d;
      discard_q <= discard_d;
      abort_q   <= abort_d;
    end
  end

`ifdef DMI_JTAG_FRONTEND_TIMEOUT_EN
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign dmi_tdo_o        = dr_q[0];
  assign dmi_error_o      = error_q;
  assign dmi_req_o        = {addr_q, data_q, op_q};
  assign dmi_req_valid_o  = (state_q == REQ);
  assign dmi_resp_ready_o = (state_q == WAIT_RESP) || discard_q;

endmodule
`default_nettype wire
